// File: rtl/exe_pkg.sv
// Shared definitions for the registered execute stage: opcodes, shifter types,
// control states and NZCV bit positions.
package exe_pkg;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;
endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle into
// a DATA_W-bit accumulator; can park the finished product while hold is high.
module exe_mul_iter
  import exe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  input  logic [DATA_W-1:0] acc_init,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [DATA_W-1:0] acc_r, mcand_r, mplier_r, partial_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r, held_r, last_s;

  // Partial product of this step and the running product including it.
  always_comb begin
    partial_s = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      partial_s = partial_s + (mplier_r[i] ? (mcand_r << i) : '0);
    end
    if (held_r) begin
      product = acc_r;
    end else begin
      product = acc_r + partial_s;
    end
  end

  assign last_s = held_r | (cnt_r == CNT_W'(STEPS - 1));
  assign busy   = busy_r;
  assign done   = busy_r & last_s;

  // Operand latch, step counter and accumulator update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r   <= 1'b0;
      held_r   <= 1'b0;
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else if (flush) begin
      busy_r <= 1'b0;
      held_r <= 1'b0;
    end else if (start) begin
      busy_r   <= 1'b1;
      held_r   <= 1'b0;
      cnt_r    <= '0;
      acc_r    <= acc_init;
      mcand_r  <= mcand;
      mplier_r <= mplier;
    end else if (busy_r) begin
      if (last_s) begin
        if (hold) begin
          acc_r  <= product;
          held_r <= 1'b1;
        end else begin
          busy_r <= 1'b0;
          held_r <= 1'b0;
        end
      end else begin
        acc_r    <= acc_r + partial_s;
        mcand_r  <= mcand_r << MUL_STEP;
        mplier_r <= mplier_r >> MUL_STEP;
        cnt_r    <= cnt_r + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/exe_stage_pipe.sv
// Registered execute stage: ALU, Val2 shifter, branch adder and iterative
// multiplier feeding a valid/ready EXE->MEM output register.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 24,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        EXE_CMD,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              WB_EN,
  input  logic              S,
  input  logic [3:0]        Dest,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Val_Rn,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [DATA_W-1:0] Val_Rs,
  input  logic              imm,
  input  logic [11:0]       Shift_operand,
  input  logic [IMM_W-1:0]  Signed_imm_24,
  input  logic [3:0]        SR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Br_addr,
  output logic [3:0]        status,
  output logic              status_we,
  output logic              MEM_R_EN_o,
  output logic              MEM_W_EN_o,
  output logic              WB_EN_o,
  output logic [3:0]        Dest_o
);
  state_t              state_r, state_nxt_s;
  logic                out_free_s, in_ready_s, accept_s, is_mul_s, alu_load_s, mul_load_s;
  logic                mul_busy_s, mul_done_s;
  logic [DATA_W-1:0]   mul_prod_s, val2_s, add_b_s, alu_res_s, br_s, imm_ext_s;
  logic [2*DATA_W-1:0] dbl_s;
  logic [DATA_W:0]     sum_s;
  logic                add_cin_s, add_v_s, alu_c_s, alu_v_s;
  logic [3:0]          alu_flags_s;

  logic                out_valid_r, status_we_r, mem_r_r, mem_w_r, wb_r;
  logic [DATA_W-1:0]   result_r, br_r;
  logic [3:0]          status_r, dest_r;

  logic                p_mem_r_r, p_mem_w_r, p_wb_r, p_s_r;
  logic [3:0]          p_dest_r;
  logic [1:0]          p_cv_r;
  logic [DATA_W-1:0]   p_br_r;

  assign is_mul_s   = (EXE_CMD == CMD_MUL) | (EXE_CMD == CMD_MLA);
  assign out_free_s = ~out_valid_r | out_ready;
  assign in_ready_s = (state_r == IDLE) & ~mul_busy_s & ~flush & out_free_s;
  assign accept_s   = in_valid & in_ready_s;
  assign alu_load_s = accept_s & ~is_mul_s;
  assign mul_load_s = (state_r == MUL) & mul_done_s & out_free_s & ~flush;
  assign imm_ext_s  = {{(DATA_W-8){1'b0}}, Shift_operand[7:0]};
  assign br_s = PC + ({{(DATA_W-IMM_W){Signed_imm_24[IMM_W-1]}}, Signed_imm_24} << 2);

  // Val2 selection: memory offset, rotated immediate or shifted Rm.
  always_comb begin
    dbl_s  = '0;
    val2_s = Val_Rm;
    if (MEM_R_EN | MEM_W_EN) begin
      val2_s = {{(DATA_W-12){1'b0}}, Shift_operand};
    end else if (imm) begin
      dbl_s  = {imm_ext_s, imm_ext_s} >> {Shift_operand[11:8], 1'b0};
      val2_s = dbl_s[DATA_W-1:0];
    end else if (Shift_operand[11:7] == 5'd0) begin
      val2_s = Val_Rm;
    end else begin
      case (Shift_operand[6:5])
        SH_LSL:  val2_s = Val_Rm << Shift_operand[11:7];
        SH_LSR:  val2_s = Val_Rm >> Shift_operand[11:7];
        SH_ASR:  val2_s = $unsigned($signed(Val_Rm) >>> Shift_operand[11:7]);
        SH_ROR: begin
          dbl_s  = {Val_Rm, Val_Rm} >> Shift_operand[11:7];
          val2_s = dbl_s[DATA_W-1:0];
        end
        default: val2_s = Val_Rm;
      endcase
    end
  end

  // Subtractions run through the adder as Rn + ~Val2 + cin, so C is "no borrow".
  always_comb begin
    add_b_s   = val2_s;
    add_cin_s = 1'b0;
    case (EXE_CMD)
      CMD_ADC: add_cin_s = SR[FLAG_C];
      CMD_SUB: begin add_b_s = ~val2_s; add_cin_s = 1'b1;       end
      CMD_SBC: begin add_b_s = ~val2_s; add_cin_s = SR[FLAG_C]; end
      default: add_cin_s = 1'b0;
    endcase
    sum_s   = {1'b0, Val_Rn} + {1'b0, add_b_s} + {{DATA_W{1'b0}}, add_cin_s};
    add_v_s = (Val_Rn[DATA_W-1] == add_b_s[DATA_W-1]) & (sum_s[DATA_W-1] != Val_Rn[DATA_W-1]);

    alu_res_s   = '0;
    alu_c_s     = SR[FLAG_C];
    alu_v_s     = SR[FLAG_V];
    alu_flags_s = SR;
    case (EXE_CMD)
      CMD_MOV: alu_res_s = val2_s;
      CMD_MVN: alu_res_s = ~val2_s;
      CMD_AND: alu_res_s = Val_Rn & val2_s;
      CMD_ORR: alu_res_s = Val_Rn | val2_s;
      CMD_EOR: alu_res_s = Val_Rn ^ val2_s;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res_s = sum_s[DATA_W-1:0];
        alu_c_s   = sum_s[DATA_W];
        alu_v_s   = add_v_s;
      end
      default: alu_res_s = '0;
    endcase
    case (EXE_CMD)
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC:
        alu_flags_s = {alu_res_s[DATA_W-1], ~|alu_res_s, alu_c_s, alu_v_s};
      default: alu_flags_s = SR;
    endcase
  end

  exe_mul_iter #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (accept_s & is_mul_s),
    .hold     (~out_free_s),
    .mcand    (Val_Rm),
    .mplier   (Val_Rs),
    .acc_init ((EXE_CMD == CMD_MLA) ? Val_Rn : '0),
    .busy     (mul_busy_s),
    .done     (mul_done_s),
    .product  (mul_prod_s)
  );

  // Control state: leave IDLE on a multiply, return once its result is stored.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = (accept_s & is_mul_s) ? MUL : IDLE;
        MUL:     state_nxt_s = (mul_done_s & out_free_s) ? IDLE : MUL;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // Sideband of an accepted multiply, replayed when its product is stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_mem_r_r <= 1'b0; p_mem_w_r <= 1'b0; p_wb_r <= 1'b0; p_s_r <= 1'b0;
      p_dest_r  <= 4'd0; p_cv_r    <= 2'd0; p_br_r <= '0;
    end else if (accept_s & is_mul_s) begin
      p_mem_r_r <= MEM_R_EN; p_mem_w_r <= MEM_W_EN; p_wb_r <= WB_EN; p_s_r <= S;
      p_dest_r  <= Dest;     p_cv_r    <= {SR[FLAG_C], SR[FLAG_V]}; p_br_r <= br_s;
    end
  end

  // EXE->MEM output register; a load while draining is a bubble-free transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0; status_we_r <= 1'b0; result_r <= '0; br_r <= '0;
      status_r    <= 4'd0; dest_r      <= 4'd0; mem_r_r  <= 1'b0; mem_w_r <= 1'b0; wb_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0; status_we_r <= 1'b0;
    end else if (mul_load_s) begin
      out_valid_r <= 1'b1; status_we_r <= p_s_r; result_r <= mul_prod_s; br_r <= p_br_r;
      status_r    <= {mul_prod_s[DATA_W-1], ~|mul_prod_s, p_cv_r};
      dest_r      <= p_dest_r; mem_r_r <= p_mem_r_r; mem_w_r <= p_mem_w_r; wb_r <= p_wb_r;
    end else if (alu_load_s) begin
      out_valid_r <= 1'b1; status_we_r <= S; result_r <= alu_res_s; br_r <= br_s;
      status_r    <= alu_flags_s;
      dest_r      <= Dest; mem_r_r <= MEM_R_EN; mem_w_r <= MEM_W_EN; wb_r <= WB_EN;
    end else if (out_ready) begin
      out_valid_r <= 1'b0; status_we_r <= 1'b0;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign status_we  = status_we_r;
  assign ALU_result = result_r;
  assign Br_addr    = br_r;
  assign status     = status_r;
  assign Dest_o     = dest_r;
  assign MEM_R_EN_o = mem_r_r;
  assign MEM_W_EN_o = mem_w_r;
  assign WB_EN_o    = wb_r;
endmodule
